// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage register with an optional 2-entry skid buffer,
// flush-to-bubble support and a saturating stall-cycle counter.
module pipe_stage_hs #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter int                SKID    = 1,
    parameter int                CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    logic [1:0]        r_occ;
    logic [1:0]        w_occ_nxt;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [CNT_W-1:0]  r_stall;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign w_out_valid = (r_occ != OCC_EMPTY);
    assign in_ready    = (SKID != 0) ? r_in_ready : (!w_out_valid || out_ready);
    assign w_push      = in_valid && in_ready && !flush;
    assign w_pop       = w_out_valid && out_ready;

    always_comb begin
        w_occ_nxt = r_occ;
        if (flush) begin
            w_occ_nxt = OCC_EMPTY;
        end else if (SKID != 0) begin
            case (r_occ)
                OCC_EMPTY: if (w_push) w_occ_nxt = OCC_ONE;
                OCC_ONE: begin
                    if (w_push && !w_pop)      w_occ_nxt = OCC_TWO;
                    else if (!w_push && w_pop) w_occ_nxt = OCC_EMPTY;
                end
                default:   if (w_pop) w_occ_nxt = OCC_ONE;
            endcase
        end else begin
            if (w_push)     w_occ_nxt = OCC_ONE;
            else if (w_pop) w_occ_nxt = OCC_EMPTY;
        end
    end

    // control state: occupancy, registered ready, stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ      <= OCC_EMPTY;
            r_in_ready <= 1'b1;
            r_stall    <= '0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_in_ready <= (w_occ_nxt != OCC_TWO);
            if (w_out_valid && !out_ready)
                r_stall <= sat_inc(r_stall);
        end
    end

    // payload storage; validity is carried entirely by r_occ
    always_ff @(posedge clk) begin
        if (r_occ == OCC_TWO && w_pop)
            r_main <= r_skid;
        else if (w_push && (r_occ == OCC_EMPTY || w_pop))
            r_main <= in_data;
        if (w_push && r_occ == OCC_ONE && !w_pop)
            r_skid <= in_data;
    end

    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? r_main : NOP_VAL;
    assign occupancy = r_occ;
    assign stall_cnt = r_stall;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: three instances (skid / no skid / 4-bit counter)
// driven from shared inputs, directed scenarios plus a random queue model.
module tb_pipe_stage_hs;

    localparam logic [31:0] NOP = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = 32'h0;

    logic        rdy [3];
    logic        ov  [3];
    logic [31:0] od  [3];
    logic [1:0]  oc  [3];
    logic [15:0] sa, sb;
    logic [3:0]  sc;

    int n_checks = 0;
    int n_fail   = 0;

    int          msz [3];
    logic [31:0] mq  [3][2];
    int          mst [3];

    always #5 clk = ~clk;

    pipe_stage_hs #(.DATA_W(32), .NOP_VAL(NOP), .SKID(1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .occupancy(oc[0]), .stall_cnt(sa));

    pipe_stage_hs #(.DATA_W(32), .NOP_VAL(NOP), .SKID(0), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .occupancy(oc[1]), .stall_cnt(sb));

    pipe_stage_hs #(.DATA_W(32), .NOP_VAL(NOP), .SKID(1), .CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
        .occupancy(oc[2]), .stall_cnt(sc));

    function automatic int st(input int k);
        return (k == 0) ? int'(sa) : (k == 1) ? int'(sb) : int'(sc);
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'h0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            msz[k] = 0;
            mst[k] = 0;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            n_checks += 5;
            if (ov[k] !== 1'b0) begin $display("FAIL reset_valid[%0d]: got %b want 0", k, ov[k]); n_fail++; end
            if (od[k] !== NOP) begin $display("FAIL reset_data[%0d]: got %h want %h", k, od[k], NOP); n_fail++; end
            if (oc[k] !== 2'd0) begin $display("FAIL reset_occ[%0d]: got %0d want 0", k, oc[k]); n_fail++; end
            if (rdy[k] !== 1'b1) begin $display("FAIL reset_ready[%0d]: got %b want 1", k, rdy[k]); n_fail++; end
            if (st(k) != 0) begin $display("FAIL reset_stall[%0d]: got %0d want 0", k, st(k)); n_fail++; end
        end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vals[i];
            cyc();
            n_checks += 3;
            if (ov[0] !== 1'b1) begin $display("FAIL stream_valid[%0d]: got %b want 1", i, ov[0]); n_fail++; end
            if (od[0] !== vals[i]) begin $display("FAIL stream_data[%0d]: got %h want %h", i, od[0], vals[i]); n_fail++; end
            if (oc[0] !== 2'd1) begin $display("FAIL stream_occ[%0d]: got %0d want 1", i, oc[0]); n_fail++; end
        end
        in_valid = 1'b0;
        cyc();
        n_checks += 3;
        if (ov[0] !== 1'b0 || od[0] !== NOP) begin $display("FAIL stream_drain: got %b/%h want 0/%h", ov[0], od[0], NOP); n_fail++; end
        if (oc[0] !== 2'd0) begin $display("FAIL stream_drain_occ: got %0d want 0", oc[0]); n_fail++; end
        if (sa !== 16'd0) begin $display("FAIL stream_stall: got %0d want 0", sa); n_fail++; end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1'b1; in_data = 32'hA;
        cyc();
        n_checks += 1;
        if (rdy[0] !== 1'b1 || oc[0] !== 2'd1) begin $display("FAIL bp_one: got rdy=%b occ=%0d want 1/1", rdy[0], oc[0]); n_fail++; end
        in_data = 32'hB;
        cyc();
        in_valid = 1'b0; in_data = 32'h0;
        n_checks += 4;
        if (oc[0] !== 2'd2) begin $display("FAIL bp_occ: got %0d want 2", oc[0]); n_fail++; end
        if (rdy[0] !== 1'b0) begin $display("FAIL bp_ready: got %b want 0", rdy[0]); n_fail++; end
        if (od[0] !== 32'hA) begin $display("FAIL bp_head: got %h want 0000000a", od[0]); n_fail++; end
        if (sa !== 16'd1) begin $display("FAIL bp_stall1: got %0d want 1", sa); n_fail++; end
        cyc();
        n_checks += 2;
        if (od[0] !== 32'hA) begin $display("FAIL bp_hold: got %h want 0000000a", od[0]); n_fail++; end
        if (sa !== 16'd2) begin $display("FAIL bp_stall2: got %0d want 2", sa); n_fail++; end
        out_ready = 1'b1;
        cyc();
        n_checks += 2;
        if (od[0] !== 32'hB || ov[0] !== 1'b1) begin $display("FAIL bp_second: got %b/%h want 1/0000000b", ov[0], od[0]); n_fail++; end
        if (oc[0] !== 2'd1 || rdy[0] !== 1'b1) begin $display("FAIL bp_after_pop: got occ=%0d rdy=%b want 1/1", oc[0], rdy[0]); n_fail++; end
        cyc();
        n_checks += 2;
        if (ov[0] !== 1'b0 || od[0] !== NOP) begin $display("FAIL bp_empty: got %b/%h want 0/%h", ov[0], od[0], NOP); n_fail++; end
        if (sa !== 16'd2) begin $display("FAIL bp_stall_final: got %0d want 2", sa); n_fail++; end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_data = 32'h1;
        cyc();
        in_data = 32'h2;
        cyc();
        n_checks += 1;
        if (oc[0] !== 2'd2) begin $display("FAIL flush_prefill: got %0d want 2", oc[0]); n_fail++; end
        in_data = 32'hC; flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_checks += 3;
        if (ov[0] !== 1'b0) begin $display("FAIL flush_valid: got %b want 0", ov[0]); n_fail++; end
        if (od[0] !== NOP) begin $display("FAIL flush_data: got %h want %h", od[0], NOP); n_fail++; end
        if (oc[0] !== 2'd0) begin $display("FAIL flush_occ: got %0d want 0", oc[0]); n_fail++; end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks += 1;
            if (ov[0] !== 1'b0 || od[0] !== NOP) begin $display("FAIL flush_leak[%0d]: got %b/%h want 0/%h", i, ov[0], od[0], NOP); n_fail++; end
        end
    endtask

    task automatic test_noskid();
        do_reset();
        in_valid = 1'b1; in_data = 32'h5;
        cyc();
        n_checks += 1;
        if (ov[1] !== 1'b1 || od[1] !== 32'h5) begin $display("FAIL noskid_hold: got %b/%h want 1/00000005", ov[1], od[1]); n_fail++; end
        in_valid = 1'b0;
        #1;
        n_checks += 1;
        if (rdy[1] !== 1'b0) begin $display("FAIL noskid_ready_low: got %b want 0", rdy[1]); n_fail++; end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h6;
        #1;
        n_checks += 1;
        if (rdy[1] !== 1'b1) begin $display("FAIL noskid_ready_comb: got %b want 1", rdy[1]); n_fail++; end
        cyc();
        in_valid = 1'b0;
        n_checks += 2;
        if (ov[1] !== 1'b1 || od[1] !== 32'h6) begin $display("FAIL noskid_next: got %b/%h want 1/00000006", ov[1], od[1]); n_fail++; end
        if (oc[1] !== 2'd1) begin $display("FAIL noskid_occ: got %0d want 1", oc[1]); n_fail++; end
        cyc();
        n_checks += 1;
        if (ov[1] !== 1'b0 || od[1] !== NOP || oc[1] !== 2'd0) begin $display("FAIL noskid_empty: got %b/%h/%0d want 0/%h/0", ov[1], od[1], oc[1], NOP); n_fail++; end
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1; in_data = 32'h77;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (i == 13) begin
                n_checks += 1;
                if (sc !== 4'd14) begin $display("FAIL sat_before: got %0d want 14", sc); n_fail++; end
            end
            if (i == 14) begin
                n_checks += 1;
                if (sc !== 4'd15) begin $display("FAIL sat_reach: got %0d want 15", sc); n_fail++; end
            end
        end
        n_checks += 2;
        if (sc !== 4'd15) begin $display("FAIL sat_hold: got %0d want 15", sc); n_fail++; end
        if (od[2] !== 32'h77) begin $display("FAIL sat_data_stable: got %h want 00000077", od[2]); n_fail++; end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_valid = 1'b1; in_data = 32'h31;
        cyc();
        in_data = 32'h32;
        cyc();
        in_valid = 1'b0;
        n_checks += 1;
        if (oc[0] !== 2'd2) begin $display("FAIL areset_prefill: got %0d want 2", oc[0]); n_fail++; end
        #2 rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (ov[0] !== 1'b0 || od[0] !== NOP) begin $display("FAIL areset_out: got %b/%h want 0/%h", ov[0], od[0], NOP); n_fail++; end
        if (oc[0] !== 2'd0) begin $display("FAIL areset_occ: got %0d want 0", oc[0]); n_fail++; end
        if (rdy[0] !== 1'b1) begin $display("FAIL areset_ready: got %b want 1", rdy[0]); n_fail++; end
        if (sa !== 16'd0) begin $display("FAIL areset_stall: got %0d want 0", sa); n_fail++; end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            in_data   = in_valid ? $urandom : 32'hx;
            #1;
            for (int k = 0; k < 3; k++) begin
                logic        mrdy;
                logic        push;
                logic        pop;
                logic [31:0] exp_d;
                int          smax;
                smax  = (k == 2) ? 15 : 65535;
                mrdy  = (k == 1) ? (msz[k] == 0 || out_ready) : (msz[k] < 2);
                exp_d = (msz[k] > 0) ? mq[k][0] : NOP;
                n_checks += 5;
                if (ov[k] !== (msz[k] > 0)) begin $display("FAIL rnd_valid[%0d] cyc %0d: got %b want %b", k, i, ov[k], msz[k] > 0); n_fail++; end
                if (od[k] !== exp_d) begin $display("FAIL rnd_data[%0d] cyc %0d: got %h want %h", k, i, od[k], exp_d); n_fail++; end
                if (oc[k] !== 2'(msz[k])) begin $display("FAIL rnd_occ[%0d] cyc %0d: got %0d want %0d", k, i, oc[k], msz[k]); n_fail++; end
                if (rdy[k] !== mrdy) begin $display("FAIL rnd_ready[%0d] cyc %0d: got %b want %b", k, i, rdy[k], mrdy); n_fail++; end
                if (st(k) != mst[k]) begin $display("FAIL rnd_stall[%0d] cyc %0d: got %0d want %0d", k, i, st(k), mst[k]); n_fail++; end
                pop  = (msz[k] > 0) && out_ready;
                push = in_valid && mrdy && !flush;
                if (msz[k] > 0 && !out_ready && mst[k] < smax) mst[k]++;
                if (flush) begin
                    msz[k] = 0;
                end else begin
                    if (pop) begin
                        mq[k][0] = mq[k][1];
                        msz[k]--;
                    end
                    if (push) begin
                        mq[k][msz[k]] = in_data;
                        msz[k]++;
                    end
                end
            end
            cyc();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_noskid();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
